// File: rtl/mul_share_arbiter_pkg.sv
// Shared FPU package for the multiplier-sharing arbiter.
//   mulArbState_t : arbiter state encoding
//   reqIdx_t      : requester index (two requesters)
//   MUL_LAT       : multiplier latency, start cycle to done, for the default width
//   mul_lat()     : the same latency for an arbitrary operand width
//   rr_pick()     : round-robin grant between the two requesters
package mul_share_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_CLEAR,
    ARB_START,
    ARB_BUSY,
    ARB_RESP
  } mulArbState_t;

  typedef logic reqIdx_t;

  localparam int MUL_WIDTH_DEF = 24;
  localparam int MUL_LAT       = MUL_WIDTH_DEF / 4 + 3;

  function automatic int mul_lat(input int w);
    return w / 4 + 3;
  endfunction

  // One-hot grant. On a tie the requester that did not win last time wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] v, input reqIdx_t last);
    logic [1:0] g;
    g = 2'b00;
    case (v)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_radix16.sv
// radix16Mult: iterative unsigned multiplier, one radix-16 digit of mulIn2 per cycle.
//   clock   : clock
//   reset   : synchronous active-high clear (also clears a sticky done)
//   start   : one-cycle pulse, samples mulIn1/mulIn2
//   mulIn1  : multiplicand, WIDTH bits
//   mulIn2  : multiplier, WIDTH bits
//   mulOut  : exact OUTWIDTH-bit product, valid while done is high
//   done    : rises mul_lat(WIDTH) cycles after the start cycle and stays high
//             until the next reset or start
module radix16Mult
  import mul_share_arbiter_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int OUTWIDTH = 2 * WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    mulIn1,
  input  logic [WIDTH-1:0]    mulIn2,
  output logic [OUTWIDTH-1:0] mulOut,
  output logic                done
);

  localparam int NDIG = WIDTH / 4;
  localparam int LAT  = mul_lat(WIDTH);
  localparam int CW   = $clog2(LAT + 1);

  logic [OUTWIDTH-1:0] r_mcand;
  logic [OUTWIDTH-1:0] r_acc;
  logic [WIDTH-1:0]    r_mplier;
  logic [CW-1:0]       r_cnt;
  logic                r_run;
  logic                r_done;
  logic [OUTWIDTH-1:0] w_pp;

  // Partial product of the shifted multiplicand and the current low digit.
  assign w_pp = r_mcand * {{(OUTWIDTH-4){1'b0}}, r_mplier[3:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{(OUTWIDTH-WIDTH){1'b0}}, mulIn1};
      r_mplier <= mulIn2;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_run) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt < CW'(NDIG)) begin
        r_acc    <= r_acc + w_pp;
        r_mcand  <= r_mcand << 4;
        r_mplier <= r_mplier >> 4;
      end
      // The digit loop finishes after NDIG cycles; the remaining counts pad
      // the operation out to the fixed latency callers are built around.
      if (r_cnt == CW'(LAT - 2)) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign mulOut = r_acc;
  assign done   = r_done;

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: shares one radix16Mult between two requesters.
//   clock, reset          : clock, synchronous active-high reset
//   reqValid[1:0]         : requester i presents operands
//   reqReady[1:0]         : requester i accepted this cycle (one-hot or zero)
//   reqA0/reqB0, reqA1/reqB1 : operands per requester
//   respValid[1:0]        : product waiting for requester i
//   respReady[1:0]        : requester i takes the product
//   respProduct           : captured product, held until the next capture
//   busy                  : an operation is in flight
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int OUTWIDTH = 2 * WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          reqValid,
  output logic [1:0]          reqReady,
  input  logic [WIDTH-1:0]    reqA0,
  input  logic [WIDTH-1:0]    reqB0,
  input  logic [WIDTH-1:0]    reqA1,
  input  logic [WIDTH-1:0]    reqB1,
  output logic [1:0]          respValid,
  input  logic [1:0]          respReady,
  output logic [OUTWIDTH-1:0] respProduct,
  output logic                busy
);

  mulArbState_t        r_state, w_next;
  reqIdx_t             r_lastGrant, r_owner;
  logic [1:0]          r_reqReady;
  logic [WIDTH-1:0]    r_opA, r_opB;
  logic [OUTWIDTH-1:0] r_prod;

  logic [1:0]          w_pick, w_accept;
  logic                w_acc, w_respFire;
  logic                w_mulReset, w_mulStart, w_mulDone;
  logic [OUTWIDTH-1:0] w_mulOut;

  // The grant is registered: it is computed from last cycle's reqValid and
  // presented only while the block sits in ARB_IDLE, so reqReady has no
  // combinational path from any input. A requester that drops valid while
  // granted simply transfers nothing.
  assign w_pick     = rr_pick(reqValid, r_lastGrant);
  assign w_accept   = (r_state == ARB_IDLE) ? (r_reqReady & reqValid) : 2'b00;
  assign w_acc      = |w_accept;
  assign w_respFire = (r_state == ARB_RESP) && respReady[r_owner];

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:  if (w_acc) w_next = ARB_CLEAR;
      ARB_CLEAR: w_next = ARB_START;
      ARB_START: w_next = ARB_BUSY;
      ARB_BUSY:  if (w_mulDone) w_next = ARB_RESP;
      ARB_RESP:  if (w_respFire) w_next = ARB_IDLE;
      default:   w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_lastGrant <= 1'b1;
      r_owner     <= 1'b0;
      r_reqReady  <= 2'b00;
      r_opA       <= '0;
      r_opB       <= '0;
      r_prod      <= '0;
    end else begin
      r_state    <= w_next;
      r_reqReady <= (w_next == ARB_IDLE) ? w_pick : 2'b00;
      if (w_acc) begin
        r_opA       <= w_accept[1] ? reqA1 : reqA0;
        r_opB       <= w_accept[1] ? reqB1 : reqB0;
        r_owner     <= w_accept[1];
        r_lastGrant <= w_accept[1];
      end
      if (r_state == ARB_BUSY && w_mulDone) r_prod <= w_mulOut;
    end
  end

  // The clear pulse drops any done left over from the previous operation.
  assign w_mulReset = reset | (r_state == ARB_CLEAR);
  assign w_mulStart = (r_state == ARB_START);

  radix16Mult #(
    .WIDTH    (WIDTH),
    .OUTWIDTH (OUTWIDTH)
  ) u_mult (
    .clock  (clock),
    .reset  (w_mulReset),
    .start  (w_mulStart),
    .mulIn1 (r_opA),
    .mulIn2 (r_opB),
    .mulOut (w_mulOut),
    .done   (w_mulDone)
  );

  assign reqReady    = r_reqReady;
  assign respValid   = (r_state == ARB_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign respProduct = r_prod;
  assign busy        = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;
  localparam int W  = 24;
  localparam int OW = 48;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rv0 = 1'b0, rv1 = 1'b0, rr0 = 1'b1, rr1 = 1'b1;
  logic [W-1:0]  ra0 = '0, rb0 = '0, ra1 = '0, rb1 = '0;
  logic [1:0]    reqValid, reqReady, respValid, respReady;
  logic [OW-1:0] respProduct;
  logic          busy;

  assign reqValid  = {rv1, rv0};
  assign respReady = {rr1, rr0};

  mul_share_arbiter #(.WIDTH(W), .OUTWIDTH(OW)) dut (
    .clock       (clock),
    .reset       (reset),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqA0       (ra0),
    .reqB0       (rb0),
    .reqA1       (ra1),
    .reqB1       (rb1),
    .respValid   (respValid),
    .respReady   (respReady),
    .respProduct (respProduct),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int            owner;
    logic [OW-1:0] prod;
    int            acc;
  } item_t;

  item_t sb[$];
  int    glog[$];
  logic [1:0]    prevRv   = 2'b00;
  logic [OW-1:0] prevProd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request, wait for the grant, log the expected response.
  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [OW-1:0] e);
    bit ok;
    ok = 1'b0;
    if (i == 0) begin ra0 = a; rb0 = b; rv0 = 1'b1; end
    else        begin ra1 = a; rb1 = b; rv1 = 1'b1; end
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clock);
      if (reqReady[i]) begin
        ok = 1'b1;
        sb.push_back('{i, e, cyc});
        glog.push_back(i);
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL grant_timeout: requester %0d got no reqReady, required one", i);
    end
    @(posedge clock); #1;
    if (i == 0) rv0 = 1'b0; else rv1 = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clock);
      if (sb.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL idle_timeout: pending=%0d busy=%0b, required 0/0", sb.size(), busy);
    end
  endtask

  // Monitor: one-hot ready, response owner and latency, hold under stall,
  // product at each response handshake.
  always @(negedge clock) begin
    if (cyc > 0) begin
      chk("reqReady_onehot", {63'b0, reqReady == 2'b11}, 64'd0);
      if (respValid != 2'b00 && prevRv == 2'b00) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: respValid=%b, required 00 with nothing pending", respValid);
        end else begin
          chk("resp_owner", 64'(respValid), 64'(2'b01 << sb[0].owner));
          chk("resp_latency", 64'(cyc - sb[0].acc), 64'd12);
        end
      end
      if (respValid != 2'b00 && respValid == prevRv)
        chk("resp_hold", 64'(respProduct), 64'(prevProd));
      if ((respValid & respReady) != 2'b00 && sb.size() != 0) begin
        chk("product", 64'(respProduct), 64'(sb[0].prod));
        void'(sb.pop_front());
      end
      prevRv   = respValid;
      prevProd = respProduct;
    end
  end

  initial begin
    bit seen;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_reqReady", 64'(reqReady), 64'd0);
    chk("rst_respValid", 64'(respValid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", 64'(respProduct), 64'd0);

    // Both valid out of reset: requester 0 takes the first tie.
    fork
      issue(0, 24'd3, 24'd5, 48'd15);
      issue(1, 24'd7, 24'd9, 48'd63);
      begin @(posedge clock); #1 reset = 1'b0; end
    join
    wait_idle();
    chk("sim_order_len", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) begin
      chk("sim_first", 64'(glog[0]), 64'd0);
      chk("sim_second", 64'(glog[1]), 64'd1);
    end

    // Back-to-back fairness, both holding valid.
    glog.delete();
    fork
      begin
        issue(0, 24'd2, 24'd3, 48'd6);
        issue(0, 24'd10, 24'd10, 48'd100);
        issue(0, 24'h001000, 24'h001000, 48'h000001000000);
        issue(0, 24'hFFFFFF, 24'd2, 48'h000001FFFFFE);
      end
      begin
        issue(1, 24'd5, 24'd7, 48'd35);
        issue(1, 24'h123456, 24'd1, 48'h000000123456);
        issue(1, 24'd16, 24'd16, 48'd256);
        issue(1, 24'h800000, 24'd2, 48'h000001000000);
      end
    join
    wait_idle();
    chk("fair_len", 64'(glog.size()), 64'd8);
    for (int k = 0; k < glog.size() && k < 8; k++)
      chk("fair_order", 64'(glog[k]), 64'(k % 2));

    // Single full-scale request.
    issue(0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
    wait_idle();

    // Zero operand.
    issue(0, 24'h000000, 24'h800000, 48'h0);
    wait_idle();

    // Valid dropped before grant: nothing starts.
    rv1 = 1'b1;
    @(posedge clock); #1 rv1 = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("drop_busy", 64'(busy), 64'd0);
    end

    // Response backpressure on requester 1 with requester 0 waiting.
    rr1 = 1'b0;
    issue(1, 24'd11, 24'd13, 48'd143);
    fork
      issue(0, 24'd4, 24'd4, 48'd16);
    join_none
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clock);
      if (respValid[1]) seen = 1'b1;
    end
    chk("bp_seen", 64'(seen), 64'd1);
    repeat (20) begin
      @(negedge clock);
      chk("bp_hold_valid", 64'(respValid), 64'(2'b10));
      chk("bp_no_ready0", 64'(reqReady[0]), 64'd0);
    end
    @(posedge clock); #1 rr1 = 1'b1;
    wait fork;
    wait_idle();

    // Reset while the multiplier is running.
    issue(0, 24'h00ABCD, 24'h000100, 48'h000000ABCD00);
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    sb.delete();
    @(negedge clock);
    chk("midrst_respValid", 64'(respValid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_product", 64'(respProduct), 64'd0);
    repeat (10) begin
      @(negedge clock);
      chk("midrst_no_resp", 64'(respValid), 64'd0);
    end
    issue(0, 24'd2, 24'd3, 48'd6);
    wait_idle();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Owns one `radix16Mult` mantissa multiplier and shares it between two requesters, for example the FP multiply path and the divider's reciprocal step. Each request gets a round-robin grant. The block then runs the multiplier's clear-then-start sequence and returns the full-width product to the requester that issued it. It sits between the FPU execution units and the iterative multiplier, so no unit drives the multiplier directly.

## Interface
Parameters:
- `WIDTH`, 24, operand width; must be a multiple of 4.
- `OUTWIDTH`, `2*WIDTH`, product width.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `reqValid`  in  [1:0]  requester i has operands.
- `reqReady`  out  [1:0]  requester i's request is accepted this cycle.
- `reqA0`, `reqB0`  in  WIDTH  requester 0 operands.
- `reqA1`, `reqB1`  in  WIDTH  requester 1 operands.
- `respValid`  out  [1:0]  product available for requester i.
- `respReady`  in  [1:0]  requester i takes the product.
- `respProduct`  out  OUTWIDTH  product, valid while any `respValid` bit is high.
- `busy`  out  1  an operation is in flight (state is not ARB_IDLE).

## Operation
- Ready/valid handshake: a transfer happens on a cycle where valid and ready are both high. A requester holds its operands stable while valid is high.
- Grant, in ARB_IDLE only:
  - If exactly one `reqValid` bit is set, that requester wins.
  - If both are set, the winner is the requester that is not `lastGrant`.
  - `lastGrant` resets to 1, so requester 0 wins the first tie.
- `reqReady[i]` is high only in ARB_IDLE, for the winner, that cycle. At most one bit is ever set.
- On acceptance:
  - latch the operands into `opA`/`opB`;
  - latch the owner index;
  - update `lastGrant`.
- The multiplier's `mulIn1`/`mulIn2` are driven only from the latched `opA`/`opB`, never directly from requester ports.
- States:
  - ARB_IDLE: go to ARB_CLEAR on acceptance.
  - ARB_CLEAR: multiplier `reset` is asserted for exactly one cycle; go to ARB_START.
  - ARB_START: multiplier `start` is asserted for exactly one cycle; go to ARB_BUSY.
  - ARB_BUSY: wait for multiplier `done`. When it is seen, capture `mulOut` into `respProduct` and go to ARB_RESP.
  - ARB_RESP: `respValid[owner]` is high; go to ARB_IDLE on `respReady[owner]`.
- `respReady` on the non-owner bit is ignored.
- `respProduct` holds its value until the next capture.
- Arithmetic: unsigned product, `OUTWIDTH` bits exact, with no rounding or truncation. Normalization and rounding belong to the caller.

## Timing
- Reset values:
  - `reqReady` = 0, `respValid` = 0, `busy` = 0, `respProduct` = 0;
  - state = ARB_IDLE, `lastGrant` = 1.
- Multiplier reset is `reset OR (state==ARB_CLEAR)`. This clears a multiplier left in its done state by any prior operation.
- Latency: if acceptance happens in cycle t, `respValid` first rises in cycle t + `WIDTH/4` + 6. For `WIDTH` = 24 that is t + 12.
- There is exactly one operation in flight at a time. The next acceptance can happen no earlier than the cycle after the response handshake.
- Boundary conditions:
  - Requester drops `reqValid` before being granted: not an error, nothing is latched.
  - Both requesters valid back to back: they alternate strictly.
  - `respReady` already high when `respValid` rises: the response completes in that same cycle.
  - Requester stalls `respReady` indefinitely: the block stays in ARB_RESP and the other requester is starved. This is intended.
  - `reset` mid-operation: returns to ARB_IDLE next cycle. The in-flight product is dropped, and `respValid` is 0 from that cycle on.
- `reqReady` and `respValid` are decoded from registered state, with no combinational path from inputs.

## Structure
- A shared FPU package holds:
  - `mulArbState_t` (ARB_IDLE, ARB_CLEAR, ARB_START, ARB_BUSY, ARB_RESP);
  - the requester-index type;
  - the latency constant `MUL_LAT = WIDTH/4 + 3`, measured from the start cycle to `done`.
- One sub-module: `radix16Mult`, instantiated with `WIDTH` and `OUTWIDTH` passed through.
- The state machine and grant logic live in this module. They are not split out.

## Test plan
- Single request (`WIDTH` = 24): requester 0 sends A=24'hFFFFFF, B=24'hFFFFFF. Expect `respValid[0]` at acceptance+12 and `respProduct`=48'hFFFFFE000001.
- Simultaneous requests: both valid from reset, with 3×5 (requester 0) and 7×9 (requester 1). Expect requester 0 served first with 15, then requester 1 with 63. `reqReady` is never 2'b11.
- Back-to-back fairness: both requesters hold valid for 4 operations each. Expect grants in the order 0,1,0,1,0,1,0,1 and a per-owner product of `a*b` each time.
- Response backpressure: requester 1's `respReady` is held low for 20 cycles. Expect `respValid[1]` held, `respProduct` stable, and no `reqReady` from requester 0 until the handshake.
- Reset mid-operation: assert `reset` in ARB_BUSY, then issue 2×3. Expect `respValid`=0 the cycle after reset and a clean product of 6 at acceptance+12.
- Zero operands: A=0, B=24'h800000. Expect product 0 with the standard latency.
